// File: rtl/imm_decode_if.sv
// Fetch-to-execute bus for the immediate-decode stage: upstream valid/ready with
// instruction and PC, downstream valid/ready with the decoded entry.
interface imm_decode_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_pc, out_instr
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_pc, out_instr
  );
endinterface

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage with a two-entry skid buffer.
// Optional IMM_DECODE_ZICSR_EN: SYSTEM with funct3[2]=1 decodes as Z (5-bit uimm).
module imm_decode_stage #(
  parameter int unsigned XLEN = 32
) (
  input logic         clk,
  input logic         rst,
  input logic         flush,
  imm_decode_if.slave bus
);

  typedef enum logic [2:0] {
    FmtNone = 3'd0,
    FmtI    = 3'd1,
    FmtS    = 3'd2,
    FmtB    = 3'd3,
    FmtU    = 3'd4,
    FmtJ    = 3'd5,
    FmtZ    = 3'd6,
    FmtRsvd = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  logic [31:0] ins;
  logic [31:0] imm32;
  fmt_e        fmt;
  logic        illegal;
  entry_t      dec;

  assign ins = bus.in_instr;

  always_comb begin
    fmt     = FmtNone;
    illegal = 1'b0;
    case (ins[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: fmt = FmtI;
      7'b1110011: begin
`ifdef IMM_DECODE_ZICSR_EN
        fmt = ins[14] ? FmtZ : FmtI;
`else
        fmt = FmtI;
`endif
      end
      7'b0100011: fmt = FmtS;
      7'b1100011: fmt = FmtB;
      7'b0110111, 7'b0010111: fmt = FmtU;
      7'b1101111: fmt = FmtJ;
      7'b0110011: fmt = FmtNone;
      7'b0011011: begin
        if (XLEN == 64) fmt = FmtI;
        else            illegal = 1'b1;
      end
      7'b0111011: begin
        if (XLEN != 64) illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Every format is built as a 32-bit value whose bit 31 is the desired extension bit;
  // Z keeps bit 31 clear so the common sign extension below zero-extends it.
  always_comb begin
    imm32 = '0;
    unique case (fmt)
      FmtI:    imm32 = {{20{ins[31]}}, ins[31:20]};
      FmtS:    imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FmtB:    imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FmtU:    imm32 = {ins[31:12], 12'b0};
      FmtJ:    imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      FmtZ:    imm32 = {27'b0, ins[19:15]};
      default: imm32 = '0;
    endcase
  end

  assign dec = '{
    imm:     XLEN'($signed(imm32)),
    fmt:     fmt,
    illegal: illegal,
    pc:      bus.in_pc,
    instr:   ins
  };

  entry_t main_q, main_d, skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   ready_q, ready_d;
  logic   accept, consume;

  assign accept  = bus.in_valid & ready_q;
  assign consume = main_valid_q & bus.out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || consume) begin
      // ready_q is low whenever the skid holds data, so no accept can coincide here.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        if (accept) main_d = dec;
        main_valid_d = accept;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign bus.in_ready    = ready_q;
  assign bus.out_valid   = main_valid_q;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_fmt     = main_q.fmt;
  assign bus.out_illegal = main_q.illegal;
  assign bus.out_pc      = main_q.pc;
  assign bus.out_instr   = main_q.instr;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: XLEN=32 and XLEN=64 instances run in lockstep, checked by
// directed vectors, handshake sequences and a randomized scoreboard against a reference model.
module tb_imm_decode_stage;

`ifdef IMM_DECODE_ZICSR_EN
  localparam bit Zicsr = 1'b1;
`else
  localparam bit Zicsr = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [63:0] pc64;

  always #5 clk = ~clk;

  imm_decode_if #(.XLEN(32)) b32 ();
  imm_decode_if #(.XLEN(64)) b64 ();

  assign b32.in_pc     = pc64[31:0];
  assign b64.in_pc     = pc64;
  assign b64.in_valid  = b32.in_valid;
  assign b64.in_instr  = b32.in_instr;
  assign b64.out_ready = b32.out_ready;

  imm_decode_stage #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(b32.slave));
  imm_decode_stage #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(b64.slave));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  // Sign-extend the low b bits of v to 64 bits.
  function automatic logic [63:0] sx(input longint v, input int b);
    longint r;
    r = v & ((longint'(1) << b) - 1);
    if (r >= (longint'(1) << (b - 1))) r = r - (longint'(1) << b);
    return r;
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input bit x64);
    exp_t   e;
    longint u;
    int     op;
    u     = longint'({32'b0, ins});
    op    = int'(ins[6:0]);
    e.imm = '0;
    e.fmt = 3'd0;
    e.ill = 1'b0;
    case (op)
      'h13, 'h03, 'h67, 'h0F: e.fmt = 3'd1;
      'h73:                   e.fmt = (Zicsr && ins[14]) ? 3'd6 : 3'd1;
      'h23:                   e.fmt = 3'd2;
      'h63:                   e.fmt = 3'd3;
      'h37, 'h17:             e.fmt = 3'd4;
      'h6F:                   e.fmt = 3'd5;
      'h33:                   e.fmt = 3'd0;
      'h1B: if (x64) e.fmt = 3'd1; else e.ill = 1'b1;
      'h3B: if (!x64) e.ill = 1'b1;
      default:                e.ill = 1'b1;
    endcase
    case (e.fmt)
      3'd1: e.imm = sx(u >> 20, 12);
      3'd2: e.imm = sx(((u >> 25) << 5) | ((u >> 7) & 31), 12);
      3'd3: e.imm = sx(((u >> 31) << 12) | (((u >> 7) & 1) << 11) | (((u >> 25) & 63) << 5)
                       | (((u >> 8) & 15) << 1), 13);
      3'd4: e.imm = sx(u & 64'hFFFF_F000, 32);
      3'd5: e.imm = sx(((u >> 31) << 20) | (((u >> 12) & 255) << 12) | (((u >> 20) & 1) << 11)
                       | (((u >> 21) & 1023) << 1), 21);
      3'd6: e.imm = (u >> 15) & 31;
      default: e.imm = '0;
    endcase
    if (!x64) e.imm = e.imm & 64'hFFFF_FFFF;
    return e;
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    exp_t        e32;
    exp_t        e64;
  } sb_t;

  sb_t q[$];
  bit  mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (flush) begin
        q.delete();
      end else begin
        if (b32.out_valid && b32.out_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got instr %h expected no entry", b32.out_instr);
          end else begin
            sb_t s;
            s = q.pop_front();
            check("sb_instr", b32.out_instr, s.instr);
            check("sb_pc32", b32.out_pc, s.pc[31:0]);
            check("sb_imm32", b32.out_imm, s.e32.imm);
            check("sb_fmt32", b32.out_fmt, s.e32.fmt);
            check("sb_ill32", b32.out_illegal, s.e32.ill);
            check("sb_valid64", b64.out_valid, 1);
            check("sb_pc64", b64.out_pc, s.pc);
            check("sb_imm64", b64.out_imm, s.e64.imm);
            check("sb_fmt64", b64.out_fmt, s.e64.fmt);
            check("sb_ill64", b64.out_illegal, s.e64.ill);
          end
        end
        if (b32.in_valid && b32.in_ready)
          q.push_back('{instr: b32.in_instr, pc: pc64,
                        e32: model(b32.in_instr, 1'b0), e64: model(b32.in_instr, 1'b1)});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        ill32;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        ill64;
  } vec_t;

  vec_t        vec[10];
  logic [31:0] bp[4];
  logic [6:0]  ops[13];
  logic [31:0] rnd;
  int          sent, got;

  initial begin
    vec[0] = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0};
    vec[1] = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFF_FFFFFFFC, 3'd2, 1'b0};
    vec[2] = '{32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 1'b0, 64'hFFFFFFFF_FFFFFFF8, 3'd3, 1'b0};
    vec[3] = '{32'h123452B7, 32'h12345000, 3'd4, 1'b0, 64'h00000000_12345000, 3'd4, 1'b0};
    vec[4] = '{32'h001000EF, 32'h00000800, 3'd5, 1'b0, 64'h00000000_00000800, 3'd5, 1'b0};
    vec[5] = '{32'h0000007F, 32'h00000000, 3'd0, 1'b1, 64'h0, 3'd0, 1'b1};
    if (Zicsr) vec[6] = '{32'h3008D073, 32'h00000011, 3'd6, 1'b0, 64'h11, 3'd6, 1'b0};
    else       vec[6] = '{32'h3008D073, 32'h00000300, 3'd1, 1'b0, 64'h300, 3'd1, 1'b0};
    vec[7] = '{32'h800002B7, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF_80000000, 3'd4, 1'b0};
    vec[8] = '{32'hFFF0001B, 32'h00000000, 3'd0, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0};
    vec[9] = '{32'h00B50533, 32'h00000000, 3'd0, 1'b0, 64'h0, 3'd0, 1'b0};
    bp  = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
    ops = '{7'h13, 7'h03, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33,
            7'h1B, 7'h3B};

    rst = 1'b1; flush = 1'b0; pc64 = '0;
    b32.in_valid = 1'b0; b32.in_instr = '0; b32.out_ready = 1'b0;
    #12;
    check("rst_out_valid", b32.out_valid, 0);
    check("rst_in_ready", b32.in_ready, 0);
    check("rst_imm", b32.out_imm, 0);
    check("rst_fmt", b32.out_fmt, 0);
    check("rst_pc64", b64.out_pc, 0);
    @(negedge clk) rst = 1'b0;
    check("rel_ready_before_edge", b32.in_ready, 0);
    @(posedge clk) #1;
    check("rel_ready_after_edge", b32.in_ready, 1);

    // Directed format table, back-to-back with out_ready=1.
    b32.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b32.in_valid = 1'b1;
      b32.in_instr = vec[i].instr;
      pc64 = 64'h100 + 64'(i * 4);
      @(posedge clk) #1;
      check("vec_valid", b32.out_valid, 1);
      check("vec_instr", b32.out_instr, vec[i].instr);
      check("vec_pc", b32.out_pc, 32'h100 + 32'(i * 4));
      check("vec_imm32", b32.out_imm, vec[i].imm32);
      check("vec_fmt32", b32.out_fmt, vec[i].fmt32);
      check("vec_ill32", b32.out_illegal, vec[i].ill32);
      check("vec_imm64", b64.out_imm, vec[i].imm64);
      check("vec_fmt64", b64.out_fmt, vec[i].fmt64);
      check("vec_ill64", b64.out_illegal, vec[i].ill64);
    end
    b32.in_valid = 1'b0;
    @(posedge clk) #1;
    check("vec_drained", b32.out_valid, 0);

    // Backpressure: out_ready low for 3 cycles, then everything must flow out in order.
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      b32.out_ready = (cyc >= 3);
      b32.in_valid  = (sent < 4);
      b32.in_instr  = bp[(sent < 4) ? sent : 3];
      @(negedge clk);
      if (cyc == 2) begin
        check("bp_ready_low", b32.in_ready, 0);
        check("bp_accepted", 64'(sent), 2);
      end
      if (cyc >= 3) check("bp_no_gap", b32.out_valid, 1);
      if (b32.out_valid && b32.out_ready) begin
        check("bp_order", b32.out_instr, bp[got]);
        got++;
      end
      if (b32.in_valid && b32.in_ready) sent++;
      @(posedge clk) #1;
    end
    check("bp_all_out", 64'(got), 4);
    b32.in_valid = 1'b0;
    @(posedge clk) #1;

    // Flush with both entries full and a pending beat; then flush against an open in_ready.
    b32.out_ready = 1'b0; b32.in_valid = 1'b1;
    b32.in_instr = 32'h00500293; @(posedge clk) #1;
    b32.in_instr = 32'h00600313; @(posedge clk) #1;
    check("fill_ready", b32.in_ready, 0);
    check("fill_valid", b32.out_valid, 1);
    b32.in_instr = 32'h00700393; flush = 1'b1;
    @(posedge clk) #1;
    check("flush_valid", b32.out_valid, 0);
    check("flush_ready", b32.in_ready, 1);
    b32.in_instr = 32'h00800413;
    @(posedge clk) #1;
    check("flush_drop_valid", b32.out_valid, 0);
    flush = 1'b0; b32.in_valid = 1'b0; b32.out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk) #1;
      check("flush_stays_empty", b32.out_valid, 0);
    end
    b32.in_valid = 1'b1; b32.in_instr = 32'h00900493;
    @(posedge clk) #1;
    b32.in_valid = 1'b0;
    check("post_flush_valid", b32.out_valid, 1);
    check("post_flush_instr", b32.out_instr, 32'h00900493);
    @(posedge clk) #1;

    // Asynchronous reset with both entries full.
    b32.out_ready = 1'b0; b32.in_valid = 1'b1;
    b32.in_instr = 32'h00A00513; @(posedge clk) #1;
    b32.in_instr = 32'h00B00593; @(posedge clk) #1;
    check("prerst_full", b32.in_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_valid32", b32.out_valid, 0);
    check("arst_valid64", b64.out_valid, 0);
    check("arst_ready", b32.in_ready, 0);
    check("arst_instr", b32.out_instr, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    check("arst_rel_ready", b32.in_ready, 1);
    check("arst_rel_valid", b32.out_valid, 0);
    b32.in_valid = 1'b0;
    @(posedge clk) #1;

    // Randomized traffic against the scoreboard.
    mon_en = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      rnd = $urandom;
      if ($urandom_range(3) != 0) rnd[6:0] = ops[$urandom_range(12)];
      b32.in_valid  = ($urandom_range(3) != 0);
      b32.in_instr  = rnd;
      pc64          = {$urandom, $urandom};
      b32.out_ready = ($urandom_range(3) != 0);
      flush         = ($urandom_range(40) == 0);
      @(posedge clk) #1;
    end
    flush = 1'b0; b32.in_valid = 1'b0; b32.out_ready = 1'b1;
    repeat (4) @(posedge clk) #1;
    check("sb_drained", 64'(q.size()), 0);
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
